// File: rtl/truth_pattern_driver.sv
// truth_pattern_driver
// Serially drives a programmed truth_detection pattern (LSB first) into the
// downstream trust evaluator. It captures the evaluator's registered response
// one cycle after each bit and summarises the run as a response vector, a
// trusted-sample count and a count of trust flips.

module truth_pattern_driver #(
    parameter int   PAT_W    = 16,
    parameter int   LEN_W    = 5,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    output logic             truth_detection,
    input  logic             trust_decision,
    output logic             busy,
    output logic             done,
    output logic [PAT_W-1:0] resp,
    output logic [LEN_W-1:0] trust_cycles,
    output logic [LEN_W-1:0] flips
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] shift_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_idx;
    logic [LEN_W-1:0] sample_idx;
    logic             last_sample;
    logic [LEN_W-1:0] len_clamped;
    logic             sample_en;

    // Clamp the requested length to the pattern width; the evaluator response
    // lags the driven bit by one cycle, so we sample from the second SEND cycle
    // through the single DRAIN cycle.
    always_comb begin
        len_clamped = (length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : length;
        sample_en   = ((state == S_SEND) && (bit_idx != '0)) || (state == S_DRAIN);
    end

    // Run controller: sequences IDLE/SEND/DRAIN/DONE, drives the serial bit and
    // accumulates the response summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            truth_detection <= IDLE_BIT;
            busy            <= 1'b0;
            done            <= 1'b0;
            resp            <= '0;
            trust_cycles    <= '0;
            flips           <= '0;
            shift_q         <= '0;
            len_q           <= '0;
            bit_idx         <= '0;
            sample_idx      <= '0;
            last_sample     <= 1'b0;
        end else begin
            done <= 1'b0;

            if (sample_en) begin
                resp         <= resp | (PAT_W'(trust_decision) << sample_idx);
                trust_cycles <= trust_cycles + LEN_W'(trust_decision);
                if ((sample_idx != '0) && (trust_decision != last_sample)) begin
                    flips <= flips + LEN_W'(1);
                end
                last_sample <= trust_decision;
                sample_idx  <= sample_idx + LEN_W'(1);
            end

            case (state)
                S_IDLE: begin
                    truth_detection <= IDLE_BIT;
                    if (start) begin
                        shift_q      <= pattern >> 1;
                        len_q        <= len_clamped;
                        bit_idx      <= '0;
                        sample_idx   <= '0;
                        last_sample  <= 1'b0;
                        resp         <= '0;
                        trust_cycles <= '0;
                        flips        <= '0;
                        if (len_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state           <= S_SEND;
                            busy            <= 1'b1;
                            truth_detection <= pattern[0];
                        end
                    end
                end

                S_SEND: begin
                    if (bit_idx == len_q - LEN_W'(1)) begin
                        truth_detection <= IDLE_BIT;
                        state           <= S_DRAIN;
                    end else begin
                        truth_detection <= shift_q[0];
                        shift_q         <= shift_q >> 1;
                        bit_idx         <= bit_idx + LEN_W'(1);
                    end
                end

                S_DRAIN: begin
                    truth_detection <= IDLE_BIT;
                    busy            <= 1'b0;
                    done            <= 1'b1;
                    state           <= S_DONE;
                end

                S_DONE: begin
                    truth_detection <= IDLE_BIT;
                    state           <= S_IDLE;
                end

                default: begin
                    truth_detection <= IDLE_BIT;
                    busy            <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_pattern_driver.sv
// Testbench for truth_pattern_driver: a simple trust evaluator sits on the
// serial link, runs are checked against a zero-run based reference model.

module tb_truth_pattern_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  length = '0;
    logic        truth_detection;
    logic        trust_decision;
    logic        busy;
    logic        done;
    logic [15:0] resp;
    logic [4:0]  trust_cycles;
    logic [4:0]  flips;

    int checks = 0;
    int errors = 0;

    logic [15:0] prev_resp = '0;
    int          prev_tc = 0;
    int          prev_fl = 0;
    bit          have_prev = 1'b0;

    truth_pattern_driver #(
        .PAT_W(16),
        .LEN_W(5),
        .IDLE_BIT(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .pattern(pattern),
        .length(length),
        .truth_detection(truth_detection),
        .trust_decision(trust_decision),
        .busy(busy),
        .done(done),
        .resp(resp),
        .trust_cycles(trust_cycles),
        .flips(flips)
    );

    always #5 clk = ~clk;

    // Downstream evaluator: a 1 restores trust, a single 0 is tolerated,
    // a second consecutive 0 drops trust.
    logic [1:0] eval_state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                eval_state <= 2'd0;
        else if (truth_detection)  eval_state <= 2'd0;
        else if (eval_state == 2'd0) eval_state <= 2'd1;
        else                       eval_state <= 2'd2;
    end
    assign trust_decision = (eval_state != 2'd2);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: trust after each bit is 1 unless the current run of zeros is two or longer.
    function automatic void refModel(input logic [15:0] pat, input int len,
                                     output logic [15:0] r, output int tc,
                                     output int fl, output int leff);
        int zrun;
        bit t;
        bit prev;
        leff = (len > 16) ? 16 : len;
        zrun = 0;
        r = '0;
        tc = 0;
        fl = 0;
        prev = 1'b0;
        for (int k = 0; k < leff; k++) begin
            if (pat[k]) zrun = 0;
            else        zrun++;
            t = (zrun < 2);
            r[k] = t;
            tc += int'(t);
            if (k > 0 && t != prev) fl++;
            prev = t;
        end
    endfunction

    task automatic applyStimulus(input logic [15:0] pat, input int len, input bit inject);
        logic [15:0] exp_resp;
        logic [15:0] tmp;
        int exp_tc, exp_fl, leff;
        int done_cyc, busy_err, td_err;
        bit exp_busy, exp_td;

        refModel(pat, len, exp_resp, exp_tc, exp_fl, leff);

        @(negedge clk);
        if (have_prev) begin
            checkOutput("hold_resp", 32'(resp), 32'(prev_resp));
            checkOutput("hold_trust_cycles", 32'(trust_cycles), 32'(prev_tc));
            checkOutput("hold_flips", 32'(flips), 32'(prev_fl));
            checkOutput("idle_done_low", 32'(done), 32'd0);
            checkOutput("idle_busy_low", 32'(busy), 32'd0);
        end
        pattern = pat;
        length  = 5'(len);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pattern = 16'($urandom);

        done_cyc = 0;
        busy_err = 0;
        td_err   = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput("clear_resp", 32'(resp), 32'd0);
                checkOutput("clear_trust_cycles", 32'(trust_cycles), 32'd0);
                checkOutput("clear_flips", 32'(flips), 32'd0);
            end
            exp_busy = (leff > 0) && (c <= leff + 1);
            tmp = pat >> (c - 1);
            exp_td = (c <= leff) ? tmp[0] : 1'b1;
            if (busy !== exp_busy) busy_err++;
            if (truth_detection !== exp_td) td_err++;
            if (done === 1'b1) done_cyc = c;
            if (inject && leff >= 3 && c == 2) begin
                start   = 1'b1;
                pattern = 16'($urandom);
            end
            if (inject && c == 3) start = 1'b0;
        end

        checkOutput("done_latency", 32'(done_cyc), (leff == 0) ? 32'd1 : 32'(leff + 2));
        checkOutput("busy_sequence_errs", 32'(busy_err), 32'd0);
        checkOutput("td_sequence_errs", 32'(td_err), 32'd0);
        checkOutput("resp", 32'(resp), 32'(exp_resp));
        checkOutput("trust_cycles", 32'(trust_cycles), 32'(exp_tc));
        checkOutput("flips", 32'(flips), 32'(exp_fl));

        if (inject && done_cyc != 0) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        prev_resp = exp_resp;
        prev_tc   = exp_tc;
        prev_fl   = exp_fl;
        have_prev = 1'b1;
    endtask

    task automatic resetMidRun();
        int stray;
        @(negedge clk);
        pattern = 16'($urandom);
        length  = 5'd8;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_td", 32'(truth_detection), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_resp", 32'(resp), 32'd0);
        checkOutput("rst_trust_cycles", 32'(trust_cycles), 32'd0);
        checkOutput("rst_flips", 32'(flips), 32'd0);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checkOutput("rst_no_done", 32'(stray), 32'd0);
        rst_n = 1'b1;
        prev_resp = '0;
        prev_tc   = 0;
        prev_fl   = 0;
        have_prev = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed hang expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] truth_pattern_driver bench starting");
        repeat (3) @(negedge clk);
        checkOutput("reset_td", 32'(truth_detection), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_resp", 32'(resp), 32'd0);
        checkOutput("reset_trust_cycles", 32'(trust_cycles), 32'd0);
        checkOutput("reset_flips", 32'(flips), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(16'h0000, 4, 1'b0);
        applyStimulus(16'b1100, 4, 1'b0);
        applyStimulus(16'h1234, 0, 1'b0);
        applyStimulus(16'hFFFF, 20, 1'b0);
        applyStimulus(16'hA5C3, 10, 1'b1);
        applyStimulus(16'h0F0F, 16, 1'b0);

        resetMidRun();
        applyStimulus(16'b1100, 4, 1'b0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'($urandom), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_pattern_driver.md
Name: truth_pattern_driver

Overview:
- Initiator/stimulus end of the truth-detection link: serially drives a programmed `truth_detection` bit pattern into the downstream trust-evaluator FSM.
- Captures the evaluator's returned `trust_decision` for every bit driven and summarises the run (response vector, trusted-cycle count, trust flips).
- Sits between a control/test host, which uses a start/busy/done handshake, and the evaluator, which has a 1-bit serial input, a registered Moore output and no enable.

Parameters:
- PAT_W, 16, maximum pattern length in bits.
- LEN_W, 5, width of `length` and of both counters; must hold PAT_W.
- IDLE_BIT, 1'b1, level driven on `truth_detection` while not sending. 1 holds the evaluator at its fully-trusted state.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send, LSB first; captured at start.
- length  in  LEN_W  number of bits to send; captured at start.
- truth_detection  out  1  serial bit to the evaluator; registered.
- trust_decision  in  1  evaluator output, returned path.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.
- resp  out  PAT_W  bit k = trust sample after bit k was applied.
- trust_cycles  out  LEN_W  count of 1s in the valid part of resp.
- flips  out  LEN_W  count of value changes between consecutive samples within the run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - `truth_detection`=IDLE_BIT, `busy`=0, `done`=0.
  - `resp`, `trust_cycles`, `flips`=0.
  - Internal pattern/length/bit index/sample counters cleared.
- States: IDLE, SEND, DRAIN, DONE.
- IDLE:
  - Drives IDLE_BIT.
  - On posedge with start=1, latch pattern into a shift register.
  - Latch len=min(length, PAT_W).
  - Clear `resp`, `trust_cycles`, `flips`.
  - If len=0, go to DONE; else go to SEND.
- SEND:
  - Cycle j (j=0..len-1, first SEND cycle is j=0) drives `truth_detection`=pattern[j].
  - After the cycle with j=len-1, go to DRAIN.
- Sampling and latency:
  - The evaluator updates on the posedge ending the cycle that drove bit k, so its output reflects bit k one cycle later.
  - At the end of SEND cycle j≥1 and at the end of the DRAIN cycle, sample `trust_decision` into resp[k], with k=j-1 (or k=len-1 for DRAIN).
  - Each sample updates `trust_cycles` (+1 if the sample is 1).
  - Each sample with k≥1 updates `flips` (+1 if it differs from the previous sample).
  - Bits of `resp` at index ≥len stay 0.
- DRAIN:
  - Lasts exactly 1 cycle.
  - Drives IDLE_BIT (this bit's effect is never sampled).
  - Then go to DONE.
- DONE:
  - Lasts 1 cycle; `done`=1, `busy`=0, drives IDLE_BIT.
  - Then go to IDLE. A start during DONE is ignored.
- Busy and timing:
  - `busy`=1 in SEND and DRAIN only.
  - Total latency is len+2 cycles from the cycle after acceptance to the done pulse. `done` is high in the (len+2)th cycle after the acceptance edge.
- Start handling: start while not IDLE is ignored (no queuing); the input pattern may change freely after acceptance.
- Results: `resp`, `trust_cycles` and `flips` are stable and valid from the DONE cycle and held until the next accepted start clears them.
- Counters never wrap: LEN_W holds PAT_W.
- Reset mid-run:
  - Immediate abort to the reset values.
  - No `done` pulse.
  - `truth_detection` returns to IDLE_BIT asynchronously with reset.

Test Plan:
- Evaluator settled at trusted (IDLE_BIT=1); start with pattern=16'h0000, length=4 -> drives 0,0,0,0; resp=16'h0001, trust_cycles=1, flips=1; done exactly 6 cycles after the acceptance edge; busy high for 5 cycles.
- From trusted; pattern=16'b1100, length=4 -> evaluator trust 1,0,1,1; resp=16'b1101, trust_cycles=3, flips=2.
- length=0 -> no SEND/DRAIN; done pulses in the cycle after acceptance; resp=0, trust_cycles=0, flips=0; busy never high.
- length=20 with PAT_W=16; pattern=16'hFFFF from trusted -> clamped to 16 bits; resp=16'hFFFF, trust_cycles=16, flips=0; done 18 cycles after acceptance.
- start re-asserted during SEND and during DONE -> ignored; results of the first run are unaffected; a start one cycle after done is accepted and clears the results.
- rst_n pulsed low mid-SEND (bit 2 of 8) -> all outputs at reset values immediately; no done; the next run behaves normally.
